// File: rtl/horblur_ctrl.sv
// ============================================================================
// horblur_ctrl: sequencer for the horizontal-blur window datapath, with edge
// replication, result tagging and an output FIFO. Optional: HORBLUR_CTRL_BYPASS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module horblur_ctrl #(
    parameter int WIN_LOG2  = 2,
    parameter int LAT       = 2,
    parameter int FIFO_LOG2 = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] line_width,
    input  logic [15:0] num_lines,
`ifdef HORBLUR_CTRL_BYPASS_EN
    input  logic        bypass,
`endif
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        blur_fill,
    output logic        blur_shift,
    output logic [31:0] blur_data,
    input  logic [31:0] blur_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    localparam int c_H     = 2 ** (WIN_LOG2 - 1);
    localparam int c_DEPTH = 2 ** FIFO_LOG2;
    localparam int c_OCC_W = $clog2(LAT + c_DEPTH + 1);

    localparam logic [16:0]          c_H17     = 17'(c_H);
    localparam logic [c_OCC_W-1:0]   c_DEPTH_W = c_OCC_W'(c_DEPTH);
    localparam logic [c_OCC_W-1:0]   c_OCC_ONE = 1;
    localparam logic [FIFO_LOG2-1:0] c_PTR_ONE = 1;
    localparam logic [FIFO_LOG2:0]   c_CNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [15:0]        r_lw;
    logic [15:0]        r_nl;
    logic [15:0]        r_line_cnt;
    logic [16:0]        r_op_cnt;
    logic [31:0]        r_last_word;
    logic [c_OCC_W-1:0] r_inflight;
    logic [LAT-1:0]     r_tv;
    logic [LAT-1:0]     r_tk;
    logic [LAT-1:0]     r_tl;

    logic [31:0]          r_mem_d [c_DEPTH];
    logic                 r_mem_l [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_wr;
    logic [FIFO_LOG2-1:0] r_rd;
    logic [FIFO_LOG2:0]   r_count;

    logic               w_byp;
    logic [16:0]        w_lw_ext;
    logic [c_OCC_W-1:0] w_occ;
    logic               w_credit;
    logic               w_op_fill;
    logic               w_op_shift;
    logic [31:0]        w_op_data;
    logic               w_op;
    logic               w_keep;
    logic               w_last;
    logic               w_exit;
    logic               w_push;
    logic               w_pop;

`ifdef HORBLUR_CTRL_BYPASS_EN
    logic r_byp;
    assign w_byp = r_byp;
`else
    assign w_byp = 1'b0;
`endif

    assign w_lw_ext = {1'b0, r_lw};
    assign w_occ    = r_inflight + c_OCC_W'(r_count);
    assign w_credit = (w_occ < c_DEPTH_W);

    always_comb begin
        w_op_fill  = 1'b0;
        w_op_shift = 1'b0;
        w_op_data  = 32'd0;
        in_ready   = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready  = w_credit;
                w_op_fill = in_valid & w_credit;
                w_op_data = in_data;
            end
            S_RUN: begin
                in_ready   = w_credit;
                w_op_shift = in_valid & w_credit;
                w_op_data  = in_data;
            end
            S_FLUSH: begin
                w_op_shift = w_credit;
                w_op_data  = r_last_word;
            end
            default: ;
        endcase
    end

    assign w_op       = w_op_fill | w_op_shift;
    assign blur_fill  = w_op_fill;
    assign blur_shift = w_op_shift;
    assign blur_data  = w_op_data;

    // Bypass ops are all keep; blur lines lead with H discarded ops
    assign w_keep = w_byp ? 1'b1 : (r_op_cnt >= c_H17);
    assign w_last = w_byp ? (r_op_cnt == w_lw_ext - 17'd1)
                          : (r_op_cnt == w_lw_ext + c_H17 - 17'd1);

    assign w_exit = r_tv[LAT-1];
    assign w_push = w_exit & r_tk[LAT-1];
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_lw        <= 16'd0;
            r_nl        <= 16'd0;
            r_line_cnt  <= 16'd0;
            r_op_cnt    <= 17'd0;
            r_last_word <= 32'd0;
`ifdef HORBLUR_CTRL_BYPASS_EN
            r_byp       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_op) begin
                r_op_cnt <= r_op_cnt + 17'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (line_width == 16'd0 || num_lines == 16'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_lw       <= line_width;
                            r_nl       <= num_lines;
                            r_line_cnt <= 16'd0;
                            r_op_cnt   <= 17'd0;
                            r_busy     <= 1'b1;
                            r_state    <= S_FILL;
`ifdef HORBLUR_CTRL_BYPASS_EN
                            r_byp      <= bypass;
`endif
                        end
                    end
                end
                S_FILL: begin
                    if (w_op) begin
                        r_last_word <= in_data;
                        if (!w_byp) begin
                            r_state <= (r_lw == 16'd1) ? S_FLUSH : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_op) begin
                        r_last_word <= in_data;
                        if (r_op_cnt == w_lw_ext - 17'd1) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == '0 && r_count == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
            // The final op of a line closes it regardless of which state issued it
            if (w_op && w_last) begin
                r_op_cnt <= 17'd0;
                if (r_line_cnt == r_nl - 16'd1) begin
                    r_state <= S_DRAIN;
                end else begin
                    r_line_cnt <= r_line_cnt + 16'd1;
                    r_state    <= S_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tv       <= '0;
            r_tk       <= '0;
            r_tl       <= '0;
            r_inflight <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                r_tv[i] <= r_tv[i-1];
                r_tk[i] <= r_tk[i-1];
                r_tl[i] <= r_tl[i-1];
            end
            r_tv[0] <= w_op;
            r_tk[0] <= w_keep;
            r_tl[0] <= w_last;
            case ({w_op, w_exit})
                2'b10:   r_inflight <= r_inflight + c_OCC_ONE;
                2'b01:   r_inflight <= r_inflight - c_OCC_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wr] <= blur_result;
            r_mem_l[r_wr] <= r_tl[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd <= r_rd + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: ;
            endcase
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem_d[r_rd] : 32'd0;
    assign out_last   = out_valid & r_mem_l[r_rd];
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign cfg_err    = r_err;

endmodule

`default_nettype wire

// File: doc/horblur_ctrl.md
Name: horblur_ctrl

Overview:
- Sequencer for the horizontal-blur window datapath: 32-bit packed pixel words, 8-bit channels R/G1/G2/B.
- Accepts a raster stream of lines from upstream, drives the datapath's fill/shift/data controls, and replicates edge words at line start and line end.
- Discards datapath results that are not centred on a real pixel and buffers the rest into an output FIFO with valid/ready backpressure.
- Sits between the frame reader and the blur datapath; the datapath result feeds back into this block.

Parameters:
- WIN_LOG2, 2: window taps = 2**WIN_LOG2; H = 2**(WIN_LOG2-1) leading/trailing replication count.
- LAT, 2: fixed datapath latency, cycles from issuing fill/shift to the matching blur_result.
- FIFO_LOG2, 2: output FIFO depth = 2**FIFO_LOG2; must be >= LAT+1.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg, begins frame
- line_width  in  16  words per line
- num_lines  in  16  lines per frame
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after final output handshake
- cfg_err  out  1  one-cycle pulse on rejected start
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted when valid&ready
- in_data  in  32  pixel word
- blur_fill  out  1  load all taps with blur_data
- blur_shift  out  1  shift blur_data into window
- blur_data  out  32  word for fill/shift
- blur_result  in  32  datapath output, valid LAT cycles after fill/shift
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream ready
- out_data  out  32  blurred word
- out_last  out  1  head word is last of a line

Behaviour:
- Reset: async clear. All outputs 0, FIFO empty, counters 0, state IDLE.
- States: IDLE, FILL, RUN, FLUSH, DRAIN.
- IDLE: on start with line_width!=0 and num_lines!=0, latch cfg, busy=1, go to FILL.
  - Zero in either field: cfg_err pulse, stay IDLE.
  - start while busy is ignored.
- credit = (inflight + fifo_count) < depth. inflight counts issued ops not yet returned.
- An op is one cycle with blur_fill or blur_shift high. At most one op per cycle.
- FILL: in_ready = credit. On accept, issue blur_fill with in_data and store it as last_word.
  - line_width==1: go to FLUSH; else go to RUN.
- RUN: in_ready = credit. Each accept issues blur_shift with in_data and updates last_word.
  - After line_width-1 shifts, go to FLUSH.
- FLUSH: issue H blur_shift ops with last_word, each gated by credit; in_ready=0.
  - After H ops: go to FILL if lines remain, else DRAIN.
- Per line: exactly line_width+H ops.
  - The first H ops are tagged discard; the remaining line_width ops are tagged keep.
  - The final keep op is tagged last.
  - This holds for any line_width >= 1, including line_width <= H.
- A LAT-deep tag pipe (op, keep, last) tracks results.
  - In the cycle the tag exits, a keep result is pushed to the FIFO together with its last bit; a discard result is dropped.
  - Op issued in cycle c: result captured at the end of cycle c+LAT; out_valid at the earliest in cycle c+LAT+1.
- FIFO: push and pop in the same cycle are legal at any occupancy; credit gating guarantees no overflow. out_valid = !empty.
- DRAIN: wait until inflight==0, FIFO empty and the final word has handshaken. Then pulse frame_done, busy=0, go to IDLE.
- Line and word counters are 16-bit; no wrap within a frame.
- Async reset mid-frame discards everything; no sync abort exists.

Optional Feature:
HORBLUR_CTRL_BYPASS_EN
- Defined: adds input port bypass (1 bit), latched at start.
  - When latched high, every accepted word is issued as blur_fill and tagged keep; FLUSH is skipped.
  - Output equals input order with correct out_last.
- Undefined: no port, blur path only.

Test Plan:
- Bench datapath model echoes blur_data delayed by LAT.
- WIN_LOG2=2, LAT=2, width=4, lines=1, in 0x10,0x20,0x30,0x40 -> 1 fill + 5 shifts (last two = 0x40); out 0x30,0x40,0x40,0x40; out_last on 4th; one frame_done.
- Width=1, lines=1, in 0xAB -> fill 0xAB + 2 shifts 0xAB; single out 0xAB with out_last=1.
- Width=3, lines=2, in 1..6 -> 6 outputs; out_last on 3rd and 6th only; FILL re-entered once; frame_done once.
- out_ready=0 for 20 cycles mid-line -> in_ready falls once inflight+fifo_count reaches 4; no word lost or duplicated after release.
- start with line_width=0 -> cfg_err pulse, busy stays 0, no ops issued.
- nrst low during RUN -> all outputs 0 immediately; a subsequent start with width=2 completes correctly.
